clk_period_meter: RTL and testbench

CLK_PERIOD_METER -- requirements
Module: clk_period_meter

---
 rtl/clk_period_meter.sv | 124 ++++++++++++
 tb/tb_clk_period_meter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_period_meter.sv
// Measures the period (and optionally the high time) of an asynchronous clock in clk_in cycles.
// Optional high-time measurement is enabled by defining DUTY_MEAS_EN.
`timescale 1ns/1ps
module clk_period_meter #(
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             meas_clk_in,
    input  logic             enable_in,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid_out,
    output logic             timeout_out,
    output logic [CNT_W-1:0] high_out
);

    typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_CYC);

    state_t           state_q;
    logic             s1_q, s2_q, s3_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] period_q;
    logic             valid_q;
    logic             timeout_q;
    logic             rise;

    // NOTE: every flop, including the synchronizer, uses non-blocking assignments so that
    // s1/s2/s3 shift by exactly one stage per edge regardless of statement order.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= meas_clk_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise  = s2_q & ~s3_q;
    assign cnt_d = cnt_q + CNT_W'(1);

    // Rise is tested before the timeout so a period of exactly TIMEOUT_CYC is still reported.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            if (!enable_in) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        cnt_q   <= '0;
                        state_q <= ARM;
                    end
                    ARM: begin
                        cnt_q <= '0;
                        if (rise) state_q <= MEASURE;
                    end
                    MEASURE: begin
                        if (rise) begin
                            period_q <= cnt_d;
                            valid_q  <= 1'b1;
                            cnt_q    <= '0;
                        end else if (cnt_d == TIMEOUT_V) begin
                            timeout_q <= 1'b1;
                            cnt_q     <= '0;
                            state_q   <= ARM;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                    default: begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef DUTY_MEAS_EN
    logic [CNT_W-1:0] hcnt_q;
    logic [CNT_W-1:0] high_q;

    // The rise cycle itself has s2 high, so it is counted into the latched value.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hcnt_q <= '0;
            high_q <= '0;
        end else if (enable_in && state_q == MEASURE) begin
            if (rise) begin
                high_q <= hcnt_q + CNT_W'(1);
                hcnt_q <= '0;
            end else begin
                hcnt_q <= hcnt_q + CNT_W'(s2_q);
            end
        end else begin
            hcnt_q <= '0;
        end
    end

    assign high_out = high_q;
`else
    assign high_out = '0;
`endif

    assign period_out       = period_q;
    assign period_valid_out = valid_q;
    assign timeout_out      = timeout_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Self-checking bench for clk_period_meter: directed phases plus random periods, compared
// every cycle against a behavioural model based on rise-edge timestamps.
`timescale 1ns/1ps
module tb_clk_period_meter;

    localparam int CNT_W       = 16;
    localparam int TIMEOUT_CYC = 1000;
`ifdef DUTY_MEAS_EN
    localparam bit HIGH_ON = 1'b1;
`else
    localparam bit HIGH_ON = 1'b0;
`endif

    logic             clk_in = 1'b0;
    logic             rst_in = 1'b0;
    logic             meas_clk_in = 1'b0;
    logic             enable_in = 1'b0;
    logic [CNT_W-1:0] period_out;
    logic             period_valid_out;
    logic             timeout_out;
    logic [CNT_W-1:0] high_out;

    clk_period_meter #(.CNT_W(CNT_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .meas_clk_in     (meas_clk_in),
        .enable_in       (enable_in),
        .period_out      (period_out),
        .period_valid_out(period_valid_out),
        .timeout_out     (timeout_out),
        .high_out        (high_out)
    );

    always #5 clk_in = ~clk_in;

    int vectors     = 0;
    int miscompares = 0;
    int val_seen    = 0;
    int to_seen     = 0;
    logic en_v      = 1'b0;

    // Reference model: meas samples delayed two edges, mode, edge index of the last rise.
    typedef enum {M_IDLE, M_ARM, M_MEAS} mode_t;
    mode_t mode   = M_IDLE;
    bit    a1 = 1'b0, a2 = 1'b0, a3 = 1'b0;
    int    k      = 0;
    int    r_idx  = 0;
    int    hi_acc = 0;
    int    exp_period = 0;
    int    exp_high   = 0;
    bit    exp_valid  = 1'b0;
    bit    exp_to     = 1'b0;

    task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, got, exp, k);
        end
    endtask

    task automatic model_edge(input logic r, input logic e, input logic m);
        bit rise;
        rise      = a2 && !a3;
        exp_valid = 1'b0;
        exp_to    = 1'b0;
        if (r) begin
            mode       = M_IDLE;
            exp_period = 0;
            exp_high   = 0;
            a1 = 1'b0; a2 = 1'b0; a3 = 1'b0;
        end else begin
            if (!e) begin
                mode = M_IDLE;
            end else begin
                case (mode)
                    M_IDLE: mode = M_ARM;
                    M_ARM: if (rise) begin
                        mode   = M_MEAS;
                        r_idx  = k;
                        hi_acc = 0;
                    end
                    M_MEAS: begin
                        if (rise) begin
                            exp_period = k - r_idx;
                            exp_high   = hi_acc + 1;
                            exp_valid  = 1'b1;
                            r_idx      = k;
                            hi_acc     = 0;
                        end else if (k - r_idx == TIMEOUT_CYC) begin
                            exp_to = 1'b1;
                            mode   = M_ARM;
                        end else begin
                            hi_acc += int'(a2);
                        end
                    end
                    default: mode = M_IDLE;
                endcase
            end
            a3 = a2; a2 = a1; a1 = m;
        end
        k++;
    endtask

    task automatic step(input logic r, input logic e, input logic m);
        rst_in      = r;
        enable_in   = e;
        meas_clk_in = m;
        @(posedge clk_in);
        model_edge(r, e, m);
        #1;
        cmp("period_out", 32'(period_out), 32'(exp_period));
        cmp("period_valid_out", 32'(period_valid_out), 32'(exp_valid));
        cmp("timeout_out", 32'(timeout_out), 32'(exp_to));
        cmp("high_out", 32'(high_out), HIGH_ON ? 32'(exp_high) : 32'd0);
        if (period_valid_out === 1'b1) val_seen++;
        if (timeout_out === 1'b1) to_seen++;
    endtask

    task automatic wave(input int hi, input int lo, input int n);
        for (int p = 0; p < n; p++) begin
            for (int i = 0; i < hi; i++) step(1'b0, en_v, 1'b1);
            for (int i = 0; i < lo; i++) step(1'b0, en_v, 1'b0);
        end
    endtask

    initial begin
        // Reset state
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
        cmp("rst_period", 32'(period_out), 32'd0);
        cmp("rst_valid", 32'(period_valid_out), 32'd0);

        // 5/5 input: period 10, high 5
        en_v = 1'b1;
        wave(5, 5, 8);
        cmp("p10_period", 32'(period_out), 32'd10);
        cmp("p10_high", 32'(high_out), HIGH_ON ? 32'd5 : 32'd0);

        // Fastest input: toggle every cycle
        val_seen = 0;
        wave(1, 1, 15);
        cmp("p2_period", 32'(period_out), 32'd2);
        cmp("p2_valid_count", 32'(val_seen), 32'd14);

        // Random high/low lengths
        for (int i = 0; i < 12; i++)
            wave(int'($urandom_range(1, 30)), int'($urandom_range(1, 30)), 2);

        // Input stops low after period 10 -> one timeout, period holds
        wave(5, 5, 3);
        to_seen = 0;
        for (int i = 0; i < 1010; i++) step(1'b0, 1'b1, 1'b0);
        cmp("stall_timeout_count", 32'(to_seen), 32'd1);
        cmp("stall_period_hold", 32'(period_out), 32'd10);
        val_seen = 0;
        wave(5, 5, 3);
        cmp("restart_valid_count", 32'(val_seen), 32'd2);

        // Period exactly TIMEOUT_CYC is reported without timeout
        to_seen = 0;
        wave(500, 500, 3);
        cmp("p1000_period", 32'(period_out), 32'd1000);
        cmp("p1000_no_timeout", 32'(to_seen), 32'd0);

        // One cycle longer always times out
        wave(500, 501, 1);
        val_seen = 0;
        to_seen  = 0;
        wave(500, 501, 2);
        cmp("p1001_no_valid", 32'(val_seen), 32'd0);
        cmp("p1001_timeouts", 32'(to_seen), 32'd2);

        // Enable dropped mid-period
        wave(5, 5, 3);
        val_seen = 0;
        step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        cmp("en_drop_no_valid", 32'(val_seen), 32'd0);
        cmp("en_drop_period_hold", 32'(period_out), 32'd10);
        wave(5, 5, 3);
        cmp("en_resume_period", 32'(period_out), 32'd10);

        // Reset pulse mid-measurement
        wave(7, 6, 2);
        wave(4, 0, 1);
        step(1'b1, 1'b1, 1'b1);
        cmp("midrst_period", 32'(period_out), 32'd0);
        cmp("midrst_high", 32'(high_out), 32'd0);
        val_seen = 0;
        wave(5, 5, 2);
        cmp("postrst_valid_count", 32'(val_seen), 32'd1);
        cmp("postrst_period", 32'(period_out), 32'd10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
